div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the RV32M `DIV`/`DIVU`/`REM`/`REMU` instructions, instantiated beside the execute stage. It consumes operands that decode has tagged with the divide result select. Execute raises `start_i` with the two forwarded operands and a signedness flag, and holds it (stalling the pipeline) until `ready_o` returns the quotient and remainder. It is a radix-2 restoring divider with one quotient bit per cycle, plus explicit handling of divide-by-zero and cancellation.

---
 rtl/div_unit.sv | 157 +++++++++++++++
 tb/tb_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with an early exit for a zero divisor and abort on annul or when start drops.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dividend_raw_q, dividend_raw_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic        quot_neg_q, quot_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_step, quot_step;
  logic [31:0] rem_fin, quot_fin;
  logic        abort;

  assign abort   = annul_i || !start_i;
  assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // The partial remainder is always below the divisor, so after the shift it fits in
  // 33 bits and a successful trial subtraction always fits back into 32.
  assign shifted   = {rem_q, quot_q[31]};
  assign fits      = shifted >= {1'b0, divisor_q};
  assign rem_step  = fits ? (shifted[31:0] - divisor_q) : shifted[31:0];
  assign quot_step = {quot_q[30:0], fits};
  assign quot_fin  = quot_neg_q ? (~quot_step + 32'd1) : quot_step;
  assign rem_fin   = rem_neg_q ? (~rem_step + 32'd1) : rem_step;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dividend_raw_d = dividend_raw_q;
    divisor_d      = divisor_q;
    rem_d          = rem_q;
    quot_d         = quot_q;
    quot_neg_d     = quot_neg_q;
    rem_neg_d      = rem_neg_q;
    result_d       = result_q;
    ready_d        = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        cnt_d    = '0;
        if (start_i && !annul_i) begin
          dividend_raw_d = opdata1_i;
          divisor_d      = op2_abs;
          quot_d         = op1_abs;
          rem_d          = '0;
          quot_neg_d     = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          rem_neg_d      = signed_div_i & opdata1_i[31];
          state_d        = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        if (abort) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = DIV_END;
          ready_d  = 1'b1;
          result_d = {dividend_raw_q, 32'hFFFF_FFFF};
        end
      end

      DIV_ON: begin
        if (abort) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = DIV_END;
            ready_d  = 1'b1;
            result_d = {rem_fin, quot_fin};
          end
        end
      end

      DIV_END: begin
        if (abort) begin
          state_d  = DIV_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DIV_FREE;
      cnt_q          <= '0;
      dividend_raw_q <= '0;
      divisor_q      <= '0;
      rem_q          <= '0;
      quot_q         <= '0;
      quot_neg_q     <= 1'b0;
      rem_neg_q      <= 1'b0;
      result_q       <= '0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dividend_raw_q <= dividend_raw_d;
      divisor_q      <= divisor_d;
      rem_q          <= rem_d;
      quot_q         <= quot_d;
      quot_neg_q     <= quot_neg_d;
      rem_neg_q      <= rem_neg_d;
      result_q       <= result_d;
      ready_q        <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands checked
// against a plain-arithmetic division model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics from plain integer arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation, scramble the operands after acceptance, measure latency,
  // hold start through DivEnd, then release by dropping start or by annul.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int hold, input bit end_annul, input string tag);
    logic [63:0] exp;
    int          exp_lat;
    int          lat;
    logic [63:0] first;
    exp     = ref_div(a, b, sgn);
    exp_lat = (b == 32'd0) ? 2 : 33;
    lat     = -1;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (k == 1) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
      if (ready) lat = k;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    first = result;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, first);
    end
    if (end_annul) annul = 1'b1;
    else start = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready), 64'd0);
    check({tag, " release result"}, result, 64'd0);
    start = 1'b0;
    annul = 1'b0;
    $display("op %s a=%h b=%h signed=%0d result=%h exp=%h latency=%0d", tag, a, b, sgn,
             first, exp, lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          seen;

    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) tick();
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    do_op(32'd100, 32'd7, 1'b0, 0, 1'b0, "udiv_100_7");
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, "sdiv_m7_2");
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0, "udiv_m7_2");
    do_op(32'd5, 32'd0, 1'b0, 0, 1'b0, "udiv_by_zero");
    do_op(32'd5, 32'd0, 1'b1, 0, 1'b0, "sdiv_by_zero");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "sdiv_overflow");
    do_op(32'd1234567, 32'd89, 1'b1, 5, 1'b0, "hold_5");
    do_op(32'hFFFF_FF00, 32'd3, 1'b1, 1, 1'b1, "annul_in_end");

    // Annul pulse in cycle N+10, start dropped for N+11, fresh 9/3 from N+12.
    opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    annul = 1'b1;
    tick();
    if (ready) seen = 1'b1;
    check("annul ready next", 64'(ready), 64'd0);
    check("annul result next", result, 64'd0);
    annul = 1'b0; start = 1'b0;
    tick();
    if (ready) seen = 1'b1;
    check("annul never ready", 64'(seen), 64'd0);
    do_op(32'd9, 32'd3, 1'b0, 0, 1'b0, "after_annul_9_3");

    // Start dropped mid-iteration aborts the same way.
    opdata1 = 32'd123456; opdata2 = 32'd789; signed_div = 1'b0; start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    tick();
    check("drop ready", 64'(ready), 64'd0);
    do_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 0, 1'b0, "after_drop");

    // Reset in cycle N+20; nothing stale may appear afterwards.
    opdata1 = 32'd77777; opdata2 = 32'd13; signed_div = 1'b0; start = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("midreset ready", 64'(ready), 64'd0);
    check("midreset result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready || result != 64'd0) seen = 1'b1;
    end
    check("midreset no stale", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, rs, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
